spm_ctrl: RTL and testbench
===========================

SPM_CTRL -- requirements
Module: spm_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock, all flops rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_async  input  1  asynchronous start request (pushbutton/foreign domain).
REQ-005 SHALL have port mcand  input  WIDTH  signed multiplicand, captured at LOAD.
REQ-006 SHALL have port mplier  input  WIDTH  signed multiplier, captured at LOAD.
REQ-007 SHALL have port p_bit  input  1  serial product bit from the serial-parallel datapath, valid in every RUN cycle.
REQ-008 SHALL have port mcand_q  output  WIDTH  held multiplicand driving the datapath parallel input.
REQ-009 SHALL have port load  output  1  one-cycle datapath clear/load strobe.
REQ-010 SHALL have port shift_en  output  1  datapath shift enable, high only in RUN.
REQ-011 SHALL have port y_bit  output  1  serial multiplier bit, LSB first.
REQ-012 SHALL have port busy  output  1  high in LOAD and RUN.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port product  output  2*WIDTH  signed result, held until next LOAD.

Function
REQ-015 SHALL pass start_async through a 3-flop synchronizer, then a rising-edge detector flop; start_pulse = sync & ~sync_d.
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-017 SHALL go IDLE->LOAD on the clock edge where start_pulse is high; start_pulse in any other state SHALL be ignored, not queued.
REQ-018 LOAD (1 cycle): load=1; mcand_q<=mcand; multiplier shift register<=mplier; counter<=0; product not modified; ->RUN.
REQ-019 RUN: shift_en=1; y_bit=shreg[0]; each cycle shreg arithmetic-shifts right (sign bit replicated) so cycles WIDTH..2*WIDTH-1 emit sign extension.
REQ-020 RUN: each cycle p_bit SHALL be shifted into the product accumulator at the MSB with right shift, so the first p_bit ends in product[0].
REQ-021 RUN SHALL last exactly 2*WIDTH cycles (counter 0..2*WIDTH-1, width $clog2(2*WIDTH)); at count 2*WIDTH-1 ->DONE.
REQ-022 DONE (1 cycle): done=1, product valid and stable; ->IDLE.
REQ-023 Latency: start_async high before edge t0 -> LOAD at t0+4, done at t0+5+2*WIDTH (edge counts).
REQ-024 start_async held high continuously SHALL cause exactly one operation.
REQ-025 product SHALL hold its value from DONE through IDLE until the next RUN begins shifting.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE and clear synchronizer, edge flop, counter, shreg, mcand_q, product; load, shift_en, y_bit, busy, done = 0.
REQ-027 Reset asserted mid-RUN SHALL abandon the operation with no done pulse; first start after release SHALL behave as from power-up.

Configuration
REQ-028 Macro SPM_CTRL_ABORT_EN: when defined, SHALL add input abort (1 bit, synchronous, active-high); abort in LOAD or RUN ->IDLE next edge, no done, product unchanged; abort in IDLE/DONE ignored.
REQ-029 Without SPM_CTRL_ABORT_EN, no abort port SHALL exist and LOAD/RUN always complete.

Structure
REQ-030 Shared package spm_pkg SHALL hold the FSM state enum (spm_state_t) and the default WIDTH constant.
REQ-031 Synchronizer+edge detector SHALL be one sub-module, start_sync (in: clk, rst_n, async_in; out: pulse).

Verification (WIDTH=8, bench uses a behavioural signed serial-parallel datapath model)
REQ-032 mcand=8'hFD (-3), mplier=8'h05, one start -> done after 16 RUN cycles, product=16'hFFF1 (-15).
REQ-033 mcand=8'h80, mplier=8'h80 -> product=16'h4000; mcand=8'h7F, mplier=8'hFF -> product=16'hFF81.
REQ-034 start_async pulsed again during RUN, and held high for 40 cycles -> exactly one done pulse each, busy never glitches.
REQ-035 rst_n low at RUN cycle 5 -> all outputs 0 same cycle, no done; next start gives correct product.
REQ-036 With SPM_CTRL_ABORT_EN: abort at RUN cycle 3 -> IDLE next edge, no done, product equals previous result.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier controller:
// the FSM state encoding and the default operand width.
package spm_pkg;

  localparam int SPM_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } spm_state_t;

endpackage

// File: rtl/spm_ctrl_start_sync.sv
// start_sync: brings an asynchronous start request into the clk domain
// (three-flop synchronizer) and turns its rising edge into a one-cycle pulse.
module start_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic [2:0] sync_q;
  logic       edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
      edge_q <= sync_q[2];
    end
  end

  // A level held high produces exactly one pulse.
  assign pulse = sync_q[2] & ~edge_q;

endmodule

// File: rtl/spm_ctrl.sv
// spm_ctrl: sequencer for a signed serial-parallel multiplier. Feeds the multiplier
// LSB-first and assembles the serial product. Define SPM_CTRL_ABORT_EN for an abort input.
module spm_ctrl
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_async,
`ifdef SPM_CTRL_ABORT_EN
  input  logic               abort,
`endif
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic               p_bit,
  output logic [WIDTH-1:0]   mcand_q,
  output logic               load,
  output logic               shift_en,
  output logic               y_bit,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(2*WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(2*WIDTH-1);

  spm_state_t       state_q, state_d;
  logic             start_pulse;
  logic             abort_hit;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] mcand_hold_q;
  logic [2*WIDTH-2:0] acc_q;
  logic [2*WIDTH-1:0] product_q;

  start_sync u_start_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (start_async),
    .pulse    (start_pulse)
  );

  always_comb begin
    abort_hit = 1'b0;
`ifdef SPM_CTRL_ABORT_EN
    abort_hit = abort;
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_pulse) state_d = LOAD;
      LOAD: state_d = abort_hit ? IDLE : RUN;
      RUN: begin
        if (abort_hit)              state_d = IDLE;
        else if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The product register only takes the finished result, so an aborted run
  // leaves the previous product visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      mcand_hold_q <= '0;
      acc_q        <= '0;
      product_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == LOAD) begin
        mcand_hold_q <= mcand;
        shreg_q      <= mplier;
        cnt_q        <= '0;
      end else if (state_q == RUN) begin
        shreg_q <= {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
        acc_q   <= {p_bit, acc_q[2*WIDTH-2:1]};
        cnt_q   <= cnt_q + CW'(1);
        if (cnt_q == LAST_CNT && !abort_hit) begin
          product_q <= {p_bit, acc_q};
        end
      end
    end
  end

  assign load     = (state_q == LOAD);
  assign shift_en = (state_q == RUN);
  assign y_bit    = shift_en & shreg_q[0];
  assign busy     = load | shift_en;
  assign done     = (state_q == DONE);
  assign mcand_q  = mcand_hold_q;
  assign product  = product_q;

endmodule

// File: tb/tb_spm_ctrl.sv
// Self-checking bench for spm_ctrl (WIDTH=8) with a behavioural signed
// serial-parallel datapath and a product scoreboard.
module tb_spm_ctrl;

  localparam int W = 8;

  logic           clk;
  logic           rstN;
  logic           startAsync;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           pBit;
  logic [W-1:0]   mcandQ;
  logic           load;
  logic           shiftEn;
  logic           yBit;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
`ifdef SPM_CTRL_ABORT_EN
  logic           abort;
`endif

  int testCount = 0;
  int failCount = 0;
  int doneCount = 0;
  int busyRises = 0;
  logic busyPrev = 1'b0;
  logic [2*W-1:0] expQ[$];

  longint accSum;
  longint termNow;
  longint sumNow;
  int     kIdx;

  spm_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rstN),
    .start_async (startAsync),
`ifdef SPM_CTRL_ABORT_EN
    .abort       (abort),
`endif
    .mcand       (mcand),
    .mplier      (mplier),
    .p_bit       (pBit),
    .mcand_q     (mcandQ),
    .load        (load),
    .shift_en    (shiftEn),
    .y_bit       (yBit),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: running sum of y_k * mcand * 2^k; bit k is final once step k is added.
  assign termNow = yBit ? (longint'($signed(mcandQ)) <<< kIdx) : 64'sd0;
  assign sumNow  = accSum + termNow;
  assign pBit    = sumNow[kIdx];

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      accSum <= 0;
      kIdx   <= 0;
    end else if (load) begin
      accSum <= 0;
      kIdx   <= 0;
    end else if (shiftEn) begin
      accSum <= sumNow;
      kIdx   <= kIdx + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input string what);
    testCount++;
    failCount++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  // Monitor: every done pulse pops and checks the oldest expected product.
  always @(negedge clk) begin
    logic [2*W-1:0] expVal;
    if (!rstN) begin
      busyPrev = 1'b0;
    end else begin
      if (busy && !busyPrev) busyRises++;
      busyPrev = busy;
      if (done) begin
        doneCount++;
        if (expQ.size() == 0) begin
          reportFail("unexpected done", $sformatf("product 0x%0h with empty scoreboard", product));
        end else begin
          expVal = expQ.pop_front();
          checkOutput("product", 32'(product), 32'(expVal));
        end
      end
    end
  end

  function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[2*W-1:0];
  endfunction

  task automatic applyStimulus(input logic [W-1:0] mc, input logic [W-1:0] mp, input logic [2*W-1:0] expVal);
    @(negedge clk);
    mcand  = mc;
    mplier = mp;
    expQ.push_back(expVal);
    startAsync = 1'b1;
  endtask

  task automatic waitDone(input int budget, input string tag);
    int base;
    int n;
    base = doneCount;
    n = 0;
    while (doneCount == base && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (doneCount == base) reportFail(tag, "no done within cycle budget");
  endtask

  task automatic waitShift(input int budget, input string tag);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      seen = shiftEn;
    end
    if (!seen) reportFail(tag, "shift_en never rose within cycle budget");
  endtask

  task automatic runOp(input logic [W-1:0] mc, input logic [W-1:0] mp, input logic [2*W-1:0] expVal, input string tag);
    applyStimulus(mc, mp, expVal);
    repeat (2) @(negedge clk);
    startAsync = 1'b0;
    waitDone(60, tag);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int loadEdge;
    int doneEdge;
    int n;
    int d0;
    int b0;
    logic [W-1:0] mc;
    logic [W-1:0] mp;

    rstN       = 1'b0;
    startAsync = 1'b0;
    mcand      = '0;
    mplier     = '0;
`ifdef SPM_CTRL_ABORT_EN
    abort      = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("reset load",     32'(load),    0);
    checkOutput("reset shift_en", 32'(shiftEn), 0);
    checkOutput("reset y_bit",    32'(yBit),    0);
    checkOutput("reset busy",     32'(busy),    0);
    checkOutput("reset done",     32'(done),    0);
    checkOutput("reset product",  32'(product), 0);
    checkOutput("reset mcand_q",  32'(mcandQ),  0);

    // First operation also measures latency in edges counted from the first edge after start.
    applyStimulus(8'hFD, 8'h05, 16'hFFF1);
    loadEdge = 0;
    doneEdge = 0;
    n = 0;
    while (doneEdge == 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 2) startAsync = 1'b0;
      if (load && loadEdge == 0) loadEdge = n;
      if (done) doneEdge = n;
    end
    checkOutput("load latency", 32'(loadEdge), 4);
    checkOutput("done latency", 32'(doneEdge), 32'(2*W + 5));
    repeat (2) @(negedge clk);

    runOp(8'h80, 8'h80, 16'h4000, "min x min");
    runOp(8'h7F, 8'hFF, 16'hFF81, "max x -1");
    runOp(8'h00, 8'h80, 16'h0000, "zero x min");

    for (int i = 0; i < 20; i++) begin
      mc = W'($urandom);
      mp = W'($urandom);
      runOp(mc, mp, refProduct(mc, mp), "random op");
    end

    // Second start while running must be ignored, not queued.
    d0 = doneCount;
    b0 = busyRises;
    applyStimulus(8'h23, 8'hE7, refProduct(8'h23, 8'hE7));
    repeat (2) @(negedge clk);
    startAsync = 1'b0;
    waitShift(20, "retrigger shift");
    repeat (4) @(negedge clk);
    startAsync = 1'b1;
    repeat (3) @(negedge clk);
    startAsync = 1'b0;
    waitDone(60, "retrigger op");
    repeat (30) @(negedge clk);
    checkOutput("retrigger done count", 32'(doneCount - d0), 1);
    checkOutput("retrigger busy rises", 32'(busyRises - b0), 1);

    // Start held high for 40 cycles gives one operation.
    d0 = doneCount;
    b0 = busyRises;
    applyStimulus(8'hC4, 8'h3B, refProduct(8'hC4, 8'h3B));
    repeat (40) @(negedge clk);
    startAsync = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("held done count", 32'(doneCount - d0), 1);
    checkOutput("held busy rises", 32'(busyRises - b0), 1);

    // Reset in RUN cycle 5 abandons the operation.
    applyStimulus(8'h5A, 8'hA5, refProduct(8'h5A, 8'hA5));
    repeat (2) @(negedge clk);
    startAsync = 1'b0;
    waitShift(20, "reset shift");
    repeat (5) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midrun reset load",     32'(load),    0);
    checkOutput("midrun reset shift_en", 32'(shiftEn), 0);
    checkOutput("midrun reset y_bit",    32'(yBit),    0);
    checkOutput("midrun reset busy",     32'(busy),    0);
    checkOutput("midrun reset done",     32'(done),    0);
    checkOutput("midrun reset product",  32'(product), 0);
    checkOutput("midrun reset mcand_q",  32'(mcandQ),  0);
    expQ.delete();
    d0 = doneCount;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("no done after reset", 32'(doneCount - d0), 0);
    runOp(8'hE9, 8'h71, refProduct(8'hE9, 8'h71), "after reset op");

`ifdef SPM_CTRL_ABORT_EN
    runOp(8'h12, 8'h34, refProduct(8'h12, 8'h34), "pre-abort op");
    d0 = doneCount;
    applyStimulus(8'h55, 8'h66, refProduct(8'h55, 8'h66));
    repeat (2) @(negedge clk);
    startAsync = 1'b0;
    waitShift(20, "abort shift");
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abort busy",    32'(busy),    0);
    checkOutput("abort product", 32'(product), 32'(refProduct(8'h12, 8'h34)));
    void'(expQ.pop_back());
    repeat (30) @(negedge clk);
    checkOutput("abort no done", 32'(doneCount - d0), 0);
    runOp(8'h9C, 8'h0B, refProduct(8'h9C, 8'h0B), "after abort op");
`endif

    checkOutput("scoreboard drained", 32'(expQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
